// File: rtl/ins_pkg.sv
// Shared constants for the instruction queue register.
package ins_pkg;

    localparam int unsigned INSTRUCTION_LEN_DEF = 6;
    localparam int unsigned DATA_LEN_DEF        = 16;

    // Encoding of ir_src: where the presented instruction came from.
    localparam logic SRC_QUEUE   = 1'b0;
    localparam logic SRC_COUNTER = 1'b1;

    localparam logic [INSTRUCTION_LEN_DEF-1:0] ZERO_INS = '0;

endpackage

// File: rtl/ins_fifo.sv
// Synchronous FIFO with clear; a push is accepted when full only if a pop
// happens in the same cycle.
module ins_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ins_queue_registor.sv
// Instruction queue register: LDIR edges push DR_in into a FIFO, decode pops
// one instruction at a time, and a nonzero micro-step counter overrides the
// presented value.
module ins_queue_registor
    import ins_pkg::*;
#(
    parameter int unsigned INSTRUCTION_LEN = INSTRUCTION_LEN_DEF,
    parameter int unsigned DATA_LEN        = DATA_LEN_DEF,
    parameter int unsigned DEPTH           = 4,
    localparam int unsigned CNT_W          = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_LEN-1:0]        DR_in,
    input  logic                       LDIR,
    input  logic [INSTRUCTION_LEN-1:0] counter_out,
    input  logic                       next_ins,
    input  logic                       flush,
    output logic [INSTRUCTION_LEN-1:0] data_out,
    output logic                       ir_valid,
    output logic                       ir_src,
    output logic [CNT_W-1:0]           q_count,
    output logic                       q_full,
    output logic                       q_empty,
    output logic                       overflow
);

    logic                       ldir_q;
    logic                       push_edge;
    logic                       cnt_sel;
    logic                       pop_req;
    logic [INSTRUCTION_LEN-1:0] head;
    logic                       unused_dr;

    // Only the low instruction field of DR is queued.
    assign unused_dr = ^DR_in;

    assign push_edge = LDIR & ~ldir_q;
    assign cnt_sel   = (counter_out != '0);
    // Counter override and flush both block the pop.
    assign pop_req   = ~flush & ~cnt_sel & next_ins & ~q_empty;

    ins_fifo #(
        .WIDTH (INSTRUCTION_LEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_edge & ~flush),
        .pop   (pop_req),
        .clear (flush),
        .din   (DR_in[INSTRUCTION_LEN-1:0]),
        .head  (head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // LDIR delay for rising-edge detection; reset to 0 so a held level pushes once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ldir_q <= 1'b0;
        else        ldir_q <= LDIR;
    end

    // Presented instruction: flush > counter override > queue pop > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= INSTRUCTION_LEN'(ZERO_INS);
            ir_valid <= 1'b0;
            ir_src   <= SRC_QUEUE;
        end else if (flush) begin
            data_out <= INSTRUCTION_LEN'(ZERO_INS);
            ir_valid <= 1'b0;
            ir_src   <= SRC_QUEUE;
        end else if (cnt_sel) begin
            data_out <= counter_out;
            ir_valid <= 1'b1;
            ir_src   <= SRC_COUNTER;
        end else if (next_ins) begin
            if (!q_empty) begin
                data_out <= head;
                ir_valid <= 1'b1;
                ir_src   <= SRC_QUEUE;
            end else begin
                ir_valid <= 1'b0;
            end
        end
    end

    // Sticky drop flag: a push edge into a full queue with no pop to make room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    overflow <= 1'b0;
        else if (flush)                                overflow <= 1'b0;
        else if (push_edge && q_full && !pop_req)      overflow <= 1'b1;
    end

endmodule
